// File: rtl/if_fetch_unit.sv
// IF-stage front half: program counter, instruction-memory address and IF/ID register.
// Handles redirects, hazard stalls and parks on misaligned or out-of-range fetches.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned MEM_BYTES = 64,
    parameter logic [31:0] NOP_WORD  = 32'h0000_0000,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             redirect,
    input  logic [31:0]      redirect_pc,
    input  logic [31:0]      ins_out,
    output logic [31:0]      ins_address,
    output logic [31:0]      if_id_instr,
    output logic [31:0]      if_id_pc_plus4,
    output logic             if_id_valid,
    output logic             fetch_fault,
    output logic [CNT_W-1:0] fetch_count
);

    localparam logic [31:0]      LAST_PC = 32'(MEM_BYTES - 4);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    function automatic logic pc_is_bad(input logic [31:0] pc);
        return (pc[1:0] != 2'b00) || (pc > LAST_PC);
    endfunction

    logic [31:0]      pc_q,    pc_d;
    logic [31:0]      instr_q, instr_d;
    logic [31:0]      pc4_q,   pc4_d;
    logic             valid_q, valid_d;
    logic             fault_q, fault_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             bad_pc_s;

    // Next-state selection: redirect beats stall, stall beats a bad PC.
    always_comb begin
        pc_d     = pc_q;
        instr_d  = instr_q;
        pc4_d    = pc4_q;
        valid_d  = valid_q;
        fault_d  = fault_q;
        cnt_d    = cnt_q;
        bad_pc_s = pc_is_bad(pc_q);
        if (redirect) begin
            pc_d    = redirect_pc;
            instr_d = NOP_WORD;
            valid_d = 1'b0;
            fault_d = 1'b0;
        end else if (stall) begin
            pc_d = pc_q;
        end else if (bad_pc_s) begin
            instr_d = NOP_WORD;
            valid_d = 1'b0;
            fault_d = 1'b1;
        end else begin
            instr_d = ins_out;
            pc4_d   = pc_q + 32'd4;
            valid_d = 1'b1;
            pc_d    = pc_q + 32'd4;
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CNT_ONE;
            end else begin
                cnt_d = cnt_q;
            end
        end
    end

    // State registers with asynchronous reset to the idle, empty pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            instr_q <= NOP_WORD;
            pc4_q   <= 32'h0000_0000;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
            cnt_q   <= {CNT_W{1'b0}};
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
            fault_q <= fault_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ins_address    = pc_q;
    assign if_id_instr    = instr_q;
    assign if_id_pc_plus4 = pc4_q;
    assign if_id_valid    = valid_q;
    assign fetch_fault    = fault_q;
    assign fetch_count    = cnt_q;

endmodule
